// File: rtl/issue_queue.sv
// Reservation station: holds renamed ops until operands are ready, then selects them for ALU/memory FUs.
// Latency: dispatch-to-issue-output minimum 2 edges (write, then registered select); wakeup-to-output 2 edges.
// Backpressure: disp_ready drops when every slot is valid; an FU with fu_ready=0 is skipped by select.
module issue_queue #(
  parameter int RS_DEPTH  = 16,
  parameter int PREG_W    = 6,
  parameter int ROB_TAG_W = 6,
  parameter int NUM_ALU   = 2,
  parameter int WB_PORTS  = 2
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    disp_valid,
  output logic                                                    disp_ready,
  input  logic [6:0]                                              disp_opcode,
  input  logic                                                    disp_class,
  input  logic [PREG_W-1:0]                                       disp_prs1,
  input  logic [PREG_W-1:0]                                       disp_prs2,
  input  logic [PREG_W-1:0]                                       disp_prd,
  input  logic [31:0]                                             disp_imm,
  input  logic [ROB_TAG_W-1:0]                                    disp_rob,
  input  logic [(2**PREG_W)-1:0]                                  ready_tbl,
  input  logic [WB_PORTS-1:0]                                     wb_valid,
  input  logic [WB_PORTS*PREG_W-1:0]                              wb_tag,
  input  logic [NUM_ALU:0]                                        fu_ready,
  output logic [NUM_ALU:0]                                        iss_valid,
  output logic [(NUM_ALU+1)*(7+3*PREG_W+32+ROB_TAG_W)-1:0]        iss_bus,
  input  logic                                                    flush,
  output logic [$clog2(RS_DEPTH):0]                               occupancy
);

  localparam int NFU   = NUM_ALU + 1;
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int OCC_W = IDX_W + 1;
  localparam int BUS_W = 7 + 3*PREG_W + 32 + ROB_TAG_W;

  // Entry state: valid bits are reset, payload is only meaningful while valid.
  logic [RS_DEPTH-1:0]  vld;
  logic [RS_DEPTH-1:0]  rdy1;
  logic [RS_DEPTH-1:0]  rdy2;
  logic [RS_DEPTH-1:0]  is_mem;
  logic [6:0]           e_opcode [RS_DEPTH];
  logic [PREG_W-1:0]    e_prd    [RS_DEPTH];
  logic [PREG_W-1:0]    e_prs1   [RS_DEPTH];
  logic [PREG_W-1:0]    e_prs2   [RS_DEPTH];
  logic [31:0]          e_imm    [RS_DEPTH];
  logic [ROB_TAG_W-1:0] e_rob    [RS_DEPTH];

  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;
  logic                 disp_fire;
  logic                 ins_rdy1;
  logic                 ins_rdy2;
  logic [RS_DEPTH-1:0]  wake1;
  logic [RS_DEPTH-1:0]  wake2;
  logic [RS_DEPTH-1:0]  elig;
  logic [RS_DEPTH-1:0]  taken;
  logic [NFU-1:0]       sel_vld;
  logic [IDX_W-1:0]     sel_idx [NFU];

  // Lowest free slot from the current valid bits only (slots freed this cycle are not bypassed).
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!vld[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign disp_ready = free_found;
  assign disp_fire  = disp_valid && disp_ready;

  // Tag compare against all broadcast ports: resident entries and the incoming op.
  always_comb begin
    wake1    = '0;
    wake2    = '0;
    ins_rdy1 = ready_tbl[disp_prs1];
    ins_rdy2 = ready_tbl[disp_prs2];
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p]) begin
        if (wb_tag[p*PREG_W +: PREG_W] == disp_prs1) ins_rdy1 = 1'b1;
        if (wb_tag[p*PREG_W +: PREG_W] == disp_prs2) ins_rdy2 = 1'b1;
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (wb_tag[p*PREG_W +: PREG_W] == e_prs1[i]) wake1[i] = 1'b1;
          if (wb_tag[p*PREG_W +: PREG_W] == e_prs2[i]) wake2[i] = 1'b1;
        end
      end
    end
  end

  assign elig = vld & rdy1 & rdy2;

  // Select: each ready ALU in order grabs the lowest eligible arithmetic entry not yet taken; memory FU likewise.
  always_comb begin
    logic found;
    taken   = '0;
    sel_vld = '0;
    found   = 1'b0;
    for (int f = 0; f < NFU; f++) sel_idx[f] = '0;
    for (int k = 0; k < NUM_ALU; k++) begin
      found = 1'b0;
      if (fu_ready[k]) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (!found && elig[i] && !is_mem[i] && !taken[i]) begin
            found      = 1'b1;
            taken[i]   = 1'b1;
            sel_vld[k] = 1'b1;
            sel_idx[k] = IDX_W'(i);
          end
        end
      end
    end
    found = 1'b0;
    if (fu_ready[NUM_ALU]) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (!found && elig[i] && is_mem[i]) begin
          found            = 1'b1;
          taken[i]         = 1'b1;
          sel_vld[NUM_ALU] = 1'b1;
          sel_idx[NUM_ALU] = IDX_W'(i);
        end
      end
    end
  end

  // Valid bits: flush/reset clear all; otherwise issued entries retire and a dispatch claims the free slot.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      vld <= '0;
    end else begin
      vld <= vld & ~taken;
      if (disp_fire) vld[free_idx] <= 1'b1;
    end
  end

  // Payload and readiness: wakeups set ready bits; a new dispatch overwrites its slot entirely.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (wake1[i]) rdy1[i] <= 1'b1;
      if (wake2[i]) rdy2[i] <= 1'b1;
    end
    if (disp_fire) begin
      is_mem[free_idx]   <= disp_class;
      e_opcode[free_idx] <= disp_opcode;
      e_prd[free_idx]    <= disp_prd;
      e_prs1[free_idx]   <= disp_prs1;
      e_prs2[free_idx]   <= disp_prs2;
      e_imm[free_idx]    <= disp_imm;
      e_rob[free_idx]    <= disp_rob;
      rdy1[free_idx]     <= ins_rdy1;
      rdy2[free_idx]     <= ins_rdy2;
    end
  end

  // Registered issue outputs; the bus of an idle FU keeps its last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss_valid <= '0;
      iss_bus   <= '0;
    end else if (flush) begin
      iss_valid <= '0;
    end else begin
      iss_valid <= sel_vld;
      for (int f = 0; f < NFU; f++) begin
        if (sel_vld[f]) begin
          iss_bus[f*BUS_W +: BUS_W] <= {e_opcode[sel_idx[f]], e_prd[sel_idx[f]], e_prs1[sel_idx[f]],
                                        e_prs2[sel_idx[f]], e_imm[sel_idx[f]], e_rob[sel_idx[f]]};
        end
      end
    end
  end

  // Occupancy is the population count of valid slots.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < RS_DEPTH; i++) occupancy = occupancy + OCC_W'(vld[i]);
  end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios with literal expectations, then randomized traffic.
// Every cycle the DUT outputs are compared with a slot-list reference model kept here.
// Inputs change #1 after the rising edge; outputs are sampled at that same point.
module tb_issue_queue;
  localparam int RS    = 16;
  localparam int PW    = 6;
  localparam int RW    = 6;
  localparam int NA    = 2;
  localparam int WP    = 2;
  localparam int NFU   = NA + 1;
  localparam int BUS_W = 7 + 3*PW + 32 + RW;
  localparam int OCC_W = $clog2(RS) + 1;

  logic              clk = 1'b0;
  logic              rst_n, disp_valid, disp_ready, disp_class, flush;
  logic [6:0]        disp_opcode;
  logic [PW-1:0]     disp_prs1, disp_prs2, disp_prd;
  logic [31:0]       disp_imm;
  logic [RW-1:0]     disp_rob;
  logic [63:0]       ready_tbl;
  logic [WP-1:0]     wb_valid;
  logic [WP*PW-1:0]  wb_tag;
  logic [NFU-1:0]    fu_ready, iss_valid;
  logic [NFU*BUS_W-1:0] iss_bus;
  logic [OCC_W-1:0]  occupancy;

  issue_queue #(.RS_DEPTH(RS), .PREG_W(PW), .ROB_TAG_W(RW), .NUM_ALU(NA), .WB_PORTS(WP)) dut (
    .clk(clk), .rst_n(rst_n), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(disp_opcode), .disp_class(disp_class), .disp_prs1(disp_prs1),
    .disp_prs2(disp_prs2), .disp_prd(disp_prd), .disp_imm(disp_imm), .disp_rob(disp_rob),
    .ready_tbl(ready_tbl), .wb_valid(wb_valid), .wb_tag(wb_tag), .fu_ready(fu_ready),
    .iss_valid(iss_valid), .iss_bus(iss_bus), .flush(flush), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    bit          mem;
    logic [6:0]  opc;
    logic [PW-1:0] prd, p1, p2;
    bit          r1, r2;
    logic [31:0] imm;
    logic [RW-1:0] rob;
  } ent_t;

  ent_t             m [RS];
  logic [NFU-1:0]   m_iss_vld;
  logic [BUS_W-1:0] m_bus [NFU];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_wb(logic [PW-1:0] t);
    for (int p = 0; p < WP; p++)
      if (wb_valid[p] && wb_tag[p*PW +: PW] == t) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: advance the slot list by one clock using the inputs currently applied.
  task automatic model_edge();
    int arith[$];
    int mems[$];
    int free_slot;
    int s;
    if (!rst_n || flush) begin
      for (int i = 0; i < RS; i++) m[i].v = 1'b0;
      m_iss_vld = '0;
      if (!rst_n) for (int f = 0; f < NFU; f++) m_bus[f] = '0;
      return;
    end
    free_slot = -1;
    for (int i = RS - 1; i >= 0; i--) if (!m[i].v) free_slot = i;
    for (int i = 0; i < RS; i++)
      if (m[i].v && m[i].r1 && m[i].r2) begin
        if (m[i].mem) mems.push_back(i); else arith.push_back(i);
      end
    m_iss_vld = '0;
    for (int k = 0; k < NA; k++)
      if (fu_ready[k] && arith.size() > 0) begin
        s = arith.pop_front();
        m_iss_vld[k] = 1'b1;
        m_bus[k] = {m[s].opc, m[s].prd, m[s].p1, m[s].p2, m[s].imm, m[s].rob};
        m[s].v = 1'b0;
      end
    if (fu_ready[NA] && mems.size() > 0) begin
      s = mems.pop_front();
      m_iss_vld[NA] = 1'b1;
      m_bus[NA] = {m[s].opc, m[s].prd, m[s].p1, m[s].p2, m[s].imm, m[s].rob};
      m[s].v = 1'b0;
    end
    for (int i = 0; i < RS; i++) begin
      if (in_wb(m[i].p1)) m[i].r1 = 1'b1;
      if (in_wb(m[i].p2)) m[i].r2 = 1'b1;
    end
    if (disp_valid && free_slot >= 0) begin
      m[free_slot].v   = 1'b1;
      m[free_slot].mem = disp_class;
      m[free_slot].opc = disp_opcode;
      m[free_slot].prd = disp_prd;
      m[free_slot].p1  = disp_prs1;
      m[free_slot].p2  = disp_prs2;
      m[free_slot].imm = disp_imm;
      m[free_slot].rob = disp_rob;
      m[free_slot].r1  = ready_tbl[disp_prs1] || in_wb(disp_prs1);
      m[free_slot].r2  = ready_tbl[disp_prs2] || in_wb(disp_prs2);
    end
  endtask

  task automatic compare_all();
    int cnt = 0;
    for (int i = 0; i < RS; i++) if (m[i].v) cnt++;
    chk("iss_valid", iss_valid, m_iss_vld);
    for (int f = 0; f < NFU; f++)
      if (m_iss_vld[f]) chk("iss_bus", iss_bus[f*BUS_W +: BUS_W], m_bus[f]);
    chk("occupancy", occupancy, cnt);
    chk("disp_ready", disp_ready, cnt < RS);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    rst_n = 1'b1; flush = 1'b0; disp_valid = 1'b0; wb_valid = '0; fu_ready = '1;
  endtask

  task automatic disp(bit mem, logic [PW-1:0] p1, logic [PW-1:0] p2, logic [RW-1:0] rob);
    disp_valid = 1'b1; disp_class = mem; disp_prs1 = p1; disp_prs2 = p2; disp_rob = rob;
    disp_opcode = 7'h13; disp_prd = 6'd1; disp_imm = 32'h0000_1000 + 32'(rob);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    disp_class = 1'b0; disp_opcode = '0; disp_prs1 = '0; disp_prs2 = '0; disp_prd = '0;
    disp_imm = '0; disp_rob = '0; wb_tag = '0; ready_tbl = 64'h18;
    for (int i = 0; i < RS; i++) begin m[i].v = 1'b0; m[i].p1 = '0; m[i].p2 = '0; end
    m_iss_vld = '0;
    #2;
    do_reset();
    chk("reset_occupancy", occupancy, 0);
    chk("reset_iss_valid", iss_valid, 0);
    chk("reset_iss_bus", iss_bus, 0);
    chk("reset_disp_ready", disp_ready, 1);

    // Ready operands: output after two edges with full bus contents.
    disp_valid = 1'b1; disp_class = 1'b0; disp_opcode = 7'h33; disp_prd = 6'd5;
    disp_prs1 = 6'd3; disp_prs2 = 6'd4; disp_imm = 32'hdeadbeef; disp_rob = 6'd7;
    step();
    chk("ready_edge1_iss", iss_valid, 0);
    chk("ready_edge1_occ", occupancy, 1);
    idle();
    step();
    chk("ready_edge2_iss", iss_valid, 3'b001);
    chk("ready_bus0", iss_bus[BUS_W-1:0], {7'h33, 6'd5, 6'd3, 6'd4, 32'hdeadbeef, 6'd7});
    chk("ready_edge2_occ", occupancy, 0);

    // Wakeup on port 1 for prs1=9.
    disp(1'b0, 6'd9, 6'd4, 6'd21);
    step();
    idle();
    step();
    chk("wake_wait_iss", iss_valid, 0);
    wb_valid = 2'b10; wb_tag = {6'd9, 6'd0};
    step();
    chk("wake_cyc_iss", iss_valid, 0);
    idle();
    step();
    chk("wake_out_iss", iss_valid, 3'b001);
    chk("wake_out_rob", iss_bus[RW-1:0], 21);

    // Same-cycle broadcast captured at insert.
    disp(1'b0, 6'd3, 6'd12, 6'd22);
    wb_valid = 2'b01; wb_tag = {6'd0, 6'd12};
    step();
    chk("samecyc_edge1_iss", iss_valid, 0);
    idle();
    step();
    chk("samecyc_edge2_iss", iss_valid, 3'b001);
    chk("samecyc_rob", iss_bus[RW-1:0], 22);

    // Select ordering across ALUs.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      disp(1'b0, 6'd3, 6'd4, 6'(10 + i));
      fu_ready = '0;
      step();
    end
    idle();
    step();
    chk("sel_iss2", iss_valid, 3'b011);
    chk("sel_alu0_rob", iss_bus[RW-1:0], 10);
    chk("sel_alu1_rob", iss_bus[BUS_W +: RW], 11);
    chk("sel_occ", occupancy, 1);
    step();
    chk("sel_next_iss", iss_valid, 3'b001);
    chk("sel_next_rob", iss_bus[RW-1:0], 12);
    disp(1'b0, 6'd3, 6'd4, 6'd13);
    fu_ready = '0;
    step();
    idle();
    fu_ready = 3'b110;
    step();
    chk("skip_iss", iss_valid, 3'b010);
    chk("skip_alu1_rob", iss_bus[BUS_W +: RW], 13);

    // Fill to capacity, drop the extra request, drain one.
    do_reset();
    ready_tbl = 64'h0000_0100_0000_0000;
    for (int i = 0; i < RS; i++) begin
      disp(1'b0, 6'(16 + i), 6'd40, 6'(i));
      step();
    end
    chk("full_occ", occupancy, 16);
    chk("full_ready", disp_ready, 0);
    disp(1'b0, 6'd40, 6'd40, 6'd63);
    step();
    chk("full_drop_occ", occupancy, 16);
    idle();
    wb_valid = 2'b01; wb_tag = {6'd0, 6'd16};
    step();
    chk("full_wake_iss", iss_valid, 0);
    idle();
    step();
    chk("full_drain_iss", iss_valid, 3'b001);
    chk("full_drain_rob", iss_bus[RW-1:0], 0);
    chk("full_drain_occ", occupancy, 15);
    chk("full_drain_ready", disp_ready, 1);

    // Flush, then reset, with five entries and a dispatch pending.
    ready_tbl = 64'h18;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < 5; i++) begin
        disp(1'b0, 6'd3, 6'd4, 6'(30 + i));
        fu_ready = '0;
        step();
      end
      chk("squash_pre_occ", occupancy, 5);
      disp(1'b0, 6'd3, 6'd4, 6'd50);
      fu_ready = '1;
      if (pass == 0) flush = 1'b1; else rst_n = 1'b0;
      step();
      chk("squash_occ", occupancy, 0);
      chk("squash_iss", iss_valid, 0);
      idle();
      for (int c = 0; c < 3; c++) begin
        step();
        chk("squash_after_iss", iss_valid, 0);
      end
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int pct;
      pct = (n / 500) % 3 == 0 ? 90 : ((n / 500) % 3 == 1 ? 50 : 20);
      rst_n       = $urandom_range(0, 299) != 0;
      flush       = $urandom_range(0, 199) == 0;
      disp_valid  = $urandom_range(0, 99) < pct;
      disp_class  = $urandom_range(0, 3) == 0;
      disp_opcode = 7'($urandom);
      disp_prs1   = 6'($urandom);
      disp_prs2   = 6'($urandom);
      disp_prd    = 6'($urandom);
      disp_imm    = $urandom;
      disp_rob    = 6'($urandom);
      ready_tbl   = {$urandom, $urandom} & {$urandom, $urandom};
      wb_valid    = 2'($urandom);
      wb_tag      = 12'($urandom);
      for (int f = 0; f < NFU; f++) fu_ready[f] = $urandom_range(0, 3) != 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
